mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Sequences and shares a single-port unified memory between two requesters: instruction fetch (driven by pc/ctrl) and data load/store (driven by ctrl in the execute phase).
- Sits between ctrl/pc/ir on one side and the memory on the other, replacing the direct pc-to-im address path.
- Inserts a configurable number of wait states per access.
- Returns registered read data with a one-cycle done pulse per requester.

Parameters:
- ADDR_W, 16, memory address width (matches pc width).
- DATA_W, 32, data/instruction word width.
- WAIT_CYC, 1, extra memory cycles per access; range 0 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_f  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid from if_done onward.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid from d_done onward.
- d_done  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_f=1, asynchronous):
  - state = IDLE, wait counter = 0.
  - All outputs 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
  - The priority pointer resets to "data".
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's owner, addr, wdata and we (fetch always reads) into internal registers.
  - Load the counter with WAIT_CYC and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_en = 1; mem_addr and mem_wdata come from the latched registers.
  - If counter > 0: decrement and stay.
  - If counter = 0: this is the final cycle. mem_we = latched we during this cycle only. On a read, mem_rdata is captured into the owner's rdata register at the end of the cycle. Then go to DONE.
- DONE: pulse the owner's done for exactly one cycle, then return to IDLE.
- Latency: from the req sampled in IDLE to the done pulse is WAIT_CYC+2 cycles. Back-to-back accesses occupy WAIT_CYC+3 cycles each.
- Requester rule: drop req on the same edge that samples done. The arbiter therefore never re-grants a stale request.
- Holding registers:
  - if_rdata and d_rdata hold their value until the next completed read by the same owner.
  - A store leaves d_rdata unchanged.
- Arbitration (base): fixed priority, data over fetch. When both reqs are high in IDLE, data is granted.
- Request changes mid-access: changes to a requester's addr, data or req during ACCESS/DONE are ignored, because the access uses the latched values.
- Fetch address: a fetch to 0xFFFF completes normally; there is no wrap logic, since the address passes through unchanged.
- Reset asserted mid-access: the access is aborted immediately, no done is issued, and mem_we drops asynchronously. The requester must reissue.
- WAIT_CYC = 0: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit priority pointer selects the favoured requester on a tie and toggles after every granted access.
  - The pointer resets to data.
  - On a simultaneous request, the owner that was not granted last is served. Neither requester can starve.
- Undefined: fixed data-over-fetch priority, and no pointer flop exists.

Decomposition:
- Shared package sisc_pkg:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_DONE (2 bits).
  - owner encoding OWN_IF=0, OWN_D=1.
  - default widths ADDR_W and DATA_W.
- One natural sub-module, mem_arb_pick:
  - Combinational winner selection from if_req, d_req and the priority pointer.
  - Under MEM_ARB_RR_EN it also carries the pointer flop.
- The state machine, counter and holding registers stay in mem_arb.

Test Plan:
- Reset then single fetch: WAIT_CYC=1, if_req with if_addr=0x0004, mem_rdata=0x10120001 → if_done pulses 3 cycles after sampling, if_rdata=0x10120001, mem_we never 1.
- Store then load: d_we=1, d_addr=0x0100, d_wdata=0xDEADBEEF → mem_we high only in the final ACCESS cycle. Then a load from 0x0100 returns d_rdata=0xDEADBEEF, and if_rdata is unchanged.
- Simultaneous requests, base build: if_req and d_req rise together → data is granted first, fetch completes WAIT_CYC+3 cycles later.
- Simultaneous requests, MEM_ARB_RR_EN: four back-to-back tie rounds → grants alternate D, IF, D, IF.
- Reset mid-access: assert rst_f during the second ACCESS cycle of a store → mem_en and mem_we drop immediately, no d_done, busy=0, outputs 0.
- WAIT_CYC=0 and address 0xFFFF: fetch from 0xFFFF → mem_addr=0xFFFF and if_done 2 cycles after the request is sampled.

Source files
------------

// File: rtl/sisc_pkg.sv
// -----------------------------------------------------------------------------
// sisc_pkg
// Shared definitions for the unified-memory arbiter and its helpers.
//   - ADDR_W / DATA_W : default address and data widths (address matches pc)
//   - state_e         : arbiter state encoding (IDLE, ACCESS, DONE)
//   - owner_e         : which requester owns the current access
// -----------------------------------------------------------------------------
package sisc_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Winner selection between the fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority, data wins a tie, no pointer state
//   defined   : a 1-bit priority pointer picks the tie winner and toggles after
//               every granted access, so neither side can starve
// Ports:
//   clk_i, rst_i  clock / async active-high reset (only with MEM_ARB_RR_EN)
//   adv_i         an access was granted this cycle (only with MEM_ARB_RR_EN)
//   if_req_i      fetch request level
//   d_req_i       data request level
//   gnt_o         at least one requester is asking
//   owner_o       which requester wins
// -----------------------------------------------------------------------------
module mem_arb_pick
   import sisc_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   adv_i,
`endif
   input  logic   if_req_i,
   input  logic   d_req_i,
   output logic   gnt_o,
   output owner_e owner_o
);

`ifdef MEM_ARB_RR_EN
   owner_e ptr_q;

   // The pointer names the favoured side for the next tie. It starts on data
   // and flips after every grant, so two back-to-back ties alternate.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= OWN_D;
      end else if (adv_i) begin
         ptr_q <= (ptr_q == OWN_D) ? OWN_IF : OWN_D;
      end
   end
`endif

   // A lone requester always wins; only a tie consults the priority rule.
   always_comb begin
      gnt_o   = if_req_i | d_req_i;
      owner_o = d_req_i ? OWN_D : OWN_IF;
      if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
         owner_o = ptr_q;
`else
         owner_o = OWN_D;
`endif
      end
   end

endmodule

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Shares one single-port memory between instruction fetch and data load/store.
// Each access: IDLE (grant + latch) -> ACCESS (WAIT_CYC+1 cycles) -> DONE
// (one-cycle done pulse to the owner). Read data is held in a per-owner
// register until that owner's next completed read.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break, see
// mem_arb_pick); default build uses fixed data-over-fetch priority.
// Ports:
//   clk, rst_f                          clock, async active-high reset
//   if_req, if_addr                     fetch request (held until if_done)
//   if_rdata, if_done                   fetched word, completion pulse
//   d_req, d_we, d_addr, d_wdata        data request (held until d_done)
//   d_rdata, d_done                     load data, completion pulse
//   mem_en, mem_we, mem_addr, mem_wdata memory command
//   mem_rdata                           memory read data
//   busy                                state is not IDLE
// -----------------------------------------------------------------------------
module mem_arb
   import sisc_pkg::*;
#(
   parameter int unsigned ADDR_W   = sisc_pkg::ADDR_W,
   parameter int unsigned DATA_W   = sisc_pkg::DATA_W,
   parameter int unsigned WAIT_CYC = 1
)(
   input  logic              clk,
   input  logic              rst_f,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

   state_e            state_q;
   owner_e            owner_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              memEn_q;
   logic              memWe_q;
   logic              ifDone_q;
   logic              dDone_q;
   logic [DATA_W-1:0] ifRdata_q;
   logic [DATA_W-1:0] dRdata_q;

   logic              gnt;
   owner_e            winner;
   logic              grantNow;

   assign grantNow = (state_q == ST_IDLE) && gnt;

   mem_arb_pick uPick (
`ifdef MEM_ARB_RR_EN
      .clk_i    (clk),
      .rst_i    (rst_f),
      .adv_i    (grantNow),
`endif
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .gnt_o    (gnt),
      .owner_o  (winner)
   );

   // Single FSM with every memory-side and requester-side output registered.
   // mem_we is pre-computed one cycle ahead so it is high only during the
   // final ACCESS cycle (cnt_q == 0). Reset clears everything at once, which
   // aborts an in-flight access without a done pulse.
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_IF;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         memEn_q   <= 1'b0;
         memWe_q   <= 1'b0;
         ifDone_q  <= 1'b0;
         dDone_q   <= 1'b0;
         ifRdata_q <= '0;
         dRdata_q  <= '0;
      end else begin
         ifDone_q <= 1'b0;
         dDone_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt) begin
                  owner_q <= winner;
                  cnt_q   <= WAIT_LD;
                  memEn_q <= 1'b1;
                  state_q <= ST_ACCESS;
                  if (winner == OWN_D) begin
                     addr_q  <= d_addr;
                     wdata_q <= d_wdata;
                     we_q    <= d_we;
                     memWe_q <= d_we && (WAIT_CYC == 0);
                  end else begin
                     addr_q  <= if_addr;
                     wdata_q <= '0;
                     we_q    <= 1'b0;
                     memWe_q <= 1'b0;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt_q != 4'd0) begin
                  cnt_q   <= cnt_q - 4'd1;
                  memWe_q <= we_q && (cnt_q == 4'd1);
               end else begin
                  memEn_q <= 1'b0;
                  memWe_q <= 1'b0;
                  state_q <= ST_DONE;
                  if (owner_q == OWN_IF) begin
                     ifRdata_q <= mem_rdata;
                     ifDone_q  <= 1'b1;
                  end else begin
                     dDone_q <= 1'b1;
                     if (!we_q) begin
                        dRdata_q <= mem_rdata;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_en    = memEn_q;
   assign mem_we    = memWe_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = ifRdata_q;
   assign if_done   = ifDone_q;
   assign d_rdata   = dRdata_q;
   assign d_done    = dDone_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
// Directed bench for mem_arb. Instance A uses WAIT_CYC=1, instance B uses
// WAIT_CYC=0. A tiny memory model answers reads from a few preloaded words
// plus the last store seen on instance A. Inputs change and outputs are
// sampled on the falling edge. Tie-break expectations follow MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_arb;

   logic        clk;
   logic        rst_f;

   logic        aIfReq, aIfDone, aDReq, aDWe, aDDone, aMemEn, aMemWe, aBusy;
   logic [15:0] aIfAddr, aDAddr, aMemAddr;
   logic [31:0] aIfRdata, aDWdata, aDRdata, aMemWdata, aMemRdata;

   logic        bIfReq, bIfDone, bDReq, bDWe, bDDone, bMemEn, bMemWe, bBusy;
   logic [15:0] bIfAddr, bDAddr, bMemAddr;
   logic [31:0] bIfRdata, bDWdata, bDRdata, bMemWdata, bMemRdata;

   logic        storeValid;
   logic [15:0] storeAddr;
   logic [31:0] storeData;

   int assertCount = 0;
   int failCount   = 0;

   mem_arb #(.ADDR_W(16), .DATA_W(32), .WAIT_CYC(1)) dutA (
      .clk(clk), .rst_f(rst_f),
      .if_req(aIfReq), .if_addr(aIfAddr), .if_rdata(aIfRdata), .if_done(aIfDone),
      .d_req(aDReq), .d_we(aDWe), .d_addr(aDAddr), .d_wdata(aDWdata),
      .d_rdata(aDRdata), .d_done(aDDone),
      .mem_en(aMemEn), .mem_we(aMemWe), .mem_addr(aMemAddr),
      .mem_wdata(aMemWdata), .mem_rdata(aMemRdata), .busy(aBusy)
   );

   mem_arb #(.ADDR_W(16), .DATA_W(32), .WAIT_CYC(0)) dutB (
      .clk(clk), .rst_f(rst_f),
      .if_req(bIfReq), .if_addr(bIfAddr), .if_rdata(bIfRdata), .if_done(bIfDone),
      .d_req(bDReq), .d_we(bDWe), .d_addr(bDAddr), .d_wdata(bDWdata),
      .d_rdata(bDRdata), .d_done(bDDone),
      .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr),
      .mem_wdata(bMemWdata), .mem_rdata(bMemRdata), .busy(bBusy)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents: a few fixed words plus the most recent store.
   function automatic logic [31:0] memLook(input logic [15:0] a, input logic sv,
                                           input logic [15:0] sa, input logic [31:0] sd);
      if (sv && a == sa) return sd;
      case (a)
         16'h0004: return 32'h10120001;
         16'h0008: return 32'h11112222;
         16'h0010: return 32'h33334444;
         16'hFFFF: return 32'hCAFEF00D;
         default:  return 32'h00000000;
      endcase
   endfunction

   always_comb aMemRdata = memLook(aMemAddr, storeValid, storeAddr, storeData);
   always_comb bMemRdata = memLook(bMemAddr, storeValid, storeAddr, storeData);

   // Commit stores from instance A on the clock edge that ends the write cycle.
   always @(posedge clk) begin
      if (aMemEn && aMemWe) begin
         storeValid <= 1'b1;
         storeAddr  <= aMemAddr;
         storeData  <= aMemWdata;
      end
   end

   // Hard stop in case something unforeseen blocks the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
      assertCount++;
      if (obs !== expVal) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, expVal);
      end
   endtask

   // Waits (bounded) for either done on instance A; owner 1 = data, 0 = fetch.
   task automatic waitDone(output int owner, output int lat);
      owner = -1;
      lat   = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         lat++;
         if (aDDone) begin owner = 1; break; end
         if (aIfDone) begin owner = 0; break; end
      end
      if (owner < 0) checkOutput("done timeout", 32'd0, 32'd1);
   endtask

   // Runs one access on instance A, dropping req on the cycle done is seen.
   task automatic applyStimulus(input bit isData, input bit we, input logic [15:0] addr,
                                input logic [31:0] wdata, output int lat, output int weCyc,
                                output int weAt, output logic [15:0] addrSeen);
      bit seenEn = 0;
      bit got    = 0;
      lat = 0; weCyc = 0; weAt = 0; addrSeen = '0;
      if (isData) begin
         aDReq = 1'b1; aDWe = we; aDAddr = addr; aDWdata = wdata;
      end else begin
         aIfReq = 1'b1; aIfAddr = addr;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         lat++;
         if (aMemWe) begin weCyc++; weAt = lat; end
         if (aMemEn && !seenEn) begin seenEn = 1; addrSeen = aMemAddr; end
         if ((isData && aDDone) || (!isData && aIfDone)) begin got = 1; break; end
      end
      if (!got) checkOutput("access timeout", 32'd0, 32'd1);
      aIfReq = 1'b0;
      aDReq  = 1'b0;
   endtask

   int          lat, weCyc, weAt, owner, prevLat;
   logic [15:0] addrSeen;
   int          expOwner[4];

   initial begin
      rst_f = 1'b1;
      aIfReq = 0; aIfAddr = '0; aDReq = 0; aDWe = 0; aDAddr = '0; aDWdata = '0;
      bIfReq = 0; bIfAddr = '0; bDReq = 0; bDWe = 0; bDAddr = '0; bDWdata = '0;
      storeValid = 0; storeAddr = '0; storeData = '0;
      repeat (2) @(negedge clk);

      // Reset state
      checkOutput("rst busy", {31'd0, aBusy}, 32'd0);
      checkOutput("rst mem_en", {31'd0, aMemEn}, 32'd0);
      checkOutput("rst mem_addr", {16'd0, aMemAddr}, 32'd0);
      checkOutput("rst if_rdata", aIfRdata, 32'd0);
      checkOutput("rst d_rdata", aDRdata, 32'd0);
      checkOutput("rst b busy", {31'd0, bBusy}, 32'd0);
      rst_f = 1'b0;
      @(negedge clk);

      // Single fetch, WAIT_CYC=1
      applyStimulus(0, 0, 16'h0004, 32'h0, lat, weCyc, weAt, addrSeen);
      checkOutput("fetch latency", lat, 32'd3);
      checkOutput("fetch rdata", aIfRdata, 32'h10120001);
      checkOutput("fetch mem_we cycles", weCyc, 32'd0);
      checkOutput("fetch mem_addr", {16'd0, addrSeen}, 32'h0004);
      checkOutput("fetch done busy", {31'd0, aBusy}, 32'd1);
      @(negedge clk);
      checkOutput("fetch done pulse width", {31'd0, aIfDone}, 32'd0);
      checkOutput("fetch idle busy", {31'd0, aBusy}, 32'd0);

      // Store then load
      applyStimulus(1, 1, 16'h0100, 32'hDEADBEEF, lat, weCyc, weAt, addrSeen);
      checkOutput("store latency", lat, 32'd3);
      checkOutput("store mem_we cycles", weCyc, 32'd1);
      checkOutput("store mem_we in final cycle", weAt, 32'd2);
      checkOutput("store keeps d_rdata", aDRdata, 32'd0);
      @(negedge clk);
      applyStimulus(1, 0, 16'h0100, 32'h0, lat, weCyc, weAt, addrSeen);
      checkOutput("load latency", lat, 32'd3);
      checkOutput("load rdata", aDRdata, 32'hDEADBEEF);
      checkOutput("load mem_we cycles", weCyc, 32'd0);
      checkOutput("load keeps if_rdata", aIfRdata, 32'h10120001);
      @(negedge clk);

      // Fresh reset so the priority pointer starts on data
      rst_f = 1'b1;
      @(negedge clk);
      rst_f = 1'b0;
      @(negedge clk);

`ifdef MEM_ARB_RR_EN
      // Four back-to-back tie rounds alternate D, IF, D, IF
      expOwner = '{1, 0, 1, 0};
      aIfReq = 1'b1; aIfAddr = 16'h0008;
      aDReq = 1'b1; aDWe = 1'b0; aDAddr = 16'h0010;
      for (int r = 0; r < 4; r++) begin
         waitDone(owner, lat);
         checkOutput($sformatf("rr owner round %0d", r), owner, expOwner[r]);
         checkOutput($sformatf("rr latency round %0d", r), lat, (r == 0) ? 32'd3 : 32'd4);
      end
      aIfReq = 1'b0;
      aDReq  = 1'b0;
      checkOutput("rr if_rdata", aIfRdata, 32'h11112222);
      checkOutput("rr d_rdata", aDRdata, 32'h33334444);
`else
      // Tie with fixed priority: data first, fetch WAIT_CYC+3 cycles later
      aIfReq = 1'b1; aIfAddr = 16'h0008;
      aDReq = 1'b1; aDWe = 1'b0; aDAddr = 16'h0010;
      waitDone(owner, lat);
      aDReq = 1'b0;
      checkOutput("tie first owner", owner, 32'd1);
      checkOutput("tie first latency", lat, 32'd3);
      checkOutput("tie d_rdata", aDRdata, 32'h33334444);
      prevLat = lat;
      waitDone(owner, lat);
      aIfReq = 1'b0;
      checkOutput("tie second owner", owner, 32'd0);
      checkOutput("tie second gap", lat, 32'd4);
      checkOutput("tie if_rdata", aIfRdata, 32'h11112222);
      checkOutput("tie total", prevLat + lat, 32'd7);
`endif
      repeat (2) @(negedge clk);

      // Reset during the final ACCESS cycle of a store
      aDReq = 1'b1; aDWe = 1'b1; aDAddr = 16'h0200; aDWdata = 32'h55AA55AA;
      repeat (2) @(negedge clk);
      checkOutput("abort pre mem_we", {31'd0, aMemWe}, 32'd1);
      rst_f = 1'b1;
      #1;
      checkOutput("abort mem_en", {31'd0, aMemEn}, 32'd0);
      checkOutput("abort mem_we", {31'd0, aMemWe}, 32'd0);
      checkOutput("abort busy", {31'd0, aBusy}, 32'd0);
      checkOutput("abort mem_addr", {16'd0, aMemAddr}, 32'd0);
      checkOutput("abort mem_wdata", aMemWdata, 32'd0);
      checkOutput("abort d_rdata", aDRdata, 32'd0);
      @(negedge clk);
      aDReq = 1'b0;
      rst_f = 1'b0;
      prevLat = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (aDDone) prevLat++;
      end
      checkOutput("abort no d_done", prevLat, 32'd0);

      // WAIT_CYC=0 fetch from the top address
      bIfReq = 1'b1; bIfAddr = 16'hFFFF;
      @(negedge clk);
      checkOutput("b mem_addr", {16'd0, bMemAddr}, 32'h0000FFFF);
      checkOutput("b mem_en", {31'd0, bMemEn}, 32'd1);
      checkOutput("b early done", {31'd0, bIfDone}, 32'd0);
      @(negedge clk);
      checkOutput("b if_done", {31'd0, bIfDone}, 32'd1);
      checkOutput("b if_rdata", bIfRdata, 32'hCAFEF00D);
      checkOutput("b mem_en after", {31'd0, bMemEn}, 32'd0);
      bIfReq = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("b idle busy", {31'd0, bBusy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
